// File: rtl/sram_pkg.sv
// Shared types and defaults for the parameterised single-port SRAM controller.
package sram_pkg;

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } sram_state_t;

  localparam int SRAM_DATA_W_DEF = 8;
  localparam int SRAM_DEPTH_DEF  = 64;

  function automatic int sram_lanes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/sram_array.sv
// Bare single-port memory: byte-lane write, read data registered every cycle.
module sram_array
  import sram_pkg::*;
#(
  parameter int DATA_W = SRAM_DATA_W_DEF,
  parameter int DEPTH  = SRAM_DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH),
  localparam int NBYTES = sram_lanes(DATA_W)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [NBYTES-1:0] be,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (be[k]) mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/sram_sp_ctrl.sv
// Single-port SRAM controller: post-reset clear, byte enables, registered read with valid/err.
// Optional macro SRAM_OUT_REG_EN adds an output pipeline stage (read latency 2).
module sram_sp_ctrl
  import sram_pkg::*;
#(
  parameter int DATA_W         = SRAM_DATA_W_DEF,
  parameter int DEPTH          = SRAM_DEPTH_DEF,
  parameter int ADDR_W         = $clog2(DEPTH),
  parameter bit CLEAR_ON_RESET = 1'b1,
  localparam int NBYTES        = sram_lanes(DATA_W)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_ce,
  input  logic              i_rw,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [NBYTES-1:0] i_be,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rvalid,
  output logic              o_ready,
  output logic              o_err
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  sram_state_t       state;
  logic [ADDR_W-1:0] ptr;
  logic              accept;
  logic              oor;
  logic              clearing;
  logic              arr_we;
  logic [NBYTES-1:0] arr_be;
  logic [ADDR_W-1:0] arr_waddr;
  logic [DATA_W-1:0] arr_wdata;
  logic [ADDR_W-1:0] arr_raddr;
  logic [DATA_W-1:0] arr_rdata;
  logic              rv1;
  logic              err1;
  logic              oor1;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rdata_hold;

  assign clearing = (state == S_CLEAR);
  assign o_ready  = (state == S_READY);
  assign accept   = i_ce && o_ready;
  assign oor      = 32'(i_addr) >= 32'(DEPTH);

  // The clear sequence owns the write port; out-of-range reads are steered to a legal row.
  assign arr_we    = clearing || (accept && !i_rw && !oor);
  assign arr_be    = clearing ? '1 : i_be;
  assign arr_waddr = clearing ? ptr : i_addr;
  assign arr_wdata = clearing ? '0 : i_wdata;
  assign arr_raddr = oor ? '0 : i_addr;

  sram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (i_clk),
    .we    (arr_we),
    .be    (arr_be),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .raddr (arr_raddr),
    .rdata (arr_rdata)
  );

  assign rd_data1 = oor1 ? '0 : arr_rdata;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
      ptr        <= '0;
      rv1        <= 1'b0;
      err1       <= 1'b0;
      oor1       <= 1'b0;
      rdata_hold <= '0;
    end else begin
      if (clearing) begin
        ptr <= ptr + 1'b1;
        if (ptr == LAST) state <= S_READY;
      end
      rv1  <= accept && i_rw;
      err1 <= accept && oor;
      if (accept && i_rw) oor1 <= oor;
      if (rv1) rdata_hold <= rd_data1;
    end
  end

`ifdef SRAM_OUT_REG_EN
  logic rv2;
  logic err2;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rv2  <= 1'b0;
      err2 <= 1'b0;
    end else begin
      rv2  <= rv1;
      err2 <= err1;
    end
  end

  // rdata_hold is already one cycle behind rv1, so it serves as the output stage.
  assign o_rvalid = rv2;
  assign o_err    = err2;
  assign o_rdata  = rdata_hold;
`else
  assign o_rvalid = rv1;
  assign o_err    = err1;
  assign o_rdata  = rv1 ? rd_data1 : rdata_hold;
`endif

endmodule
